// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the five-stage RV32I core.
//   Captures decoded operands and control from ID and presents them to EX.
//   Load-use hazard detection stalls IF/ID and injects a single bubble.
//   Row priority of the register update: reset > flush > stall > load-use > capture.
//   Optional macro ID_WB_BYPASS_EN: forward the WB write into the captured
//   rs1/rs2 data for register files that are not write-first.
module id_ex_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   // ID stage
   input  logic              i_id_valid,
   input  logic [XLEN-1:0]   i_id_pc,
   input  logic [XLEN-1:0]   i_id_rs1_data,
   input  logic [XLEN-1:0]   i_id_rs2_data,
   input  logic [XLEN-1:0]   i_id_imm,
   input  logic [4:0]        i_id_rs1,
   input  logic [4:0]        i_id_rs2,
   input  logic [4:0]        i_id_rd,
   input  logic              i_id_reg_write,
   input  logic              i_id_mem_read,
   input  logic              i_id_mem_write,
   input  logic              i_id_mem_to_reg,
   input  logic              i_id_alu_src,
   input  logic              i_id_branch,
   input  logic              i_id_jump,
   input  logic [3:0]        i_id_alu_op,
   // WB write port (used only for the optional bypass)
   input  logic              i_wb_reg_write,
   input  logic [4:0]        i_wb_rd,
   input  logic [XLEN-1:0]   i_wb_data,
   // pipeline control
   input  logic              i_flush_ex,
   input  logic              i_stall_ex,
   // EX stage
   output logic              o_ex_valid,
   output logic [XLEN-1:0]   o_ex_pc,
   output logic [XLEN-1:0]   o_ex_rs1_data,
   output logic [XLEN-1:0]   o_ex_rs2_data,
   output logic [XLEN-1:0]   o_ex_imm,
   output logic [4:0]        o_ex_rs1,
   output logic [4:0]        o_ex_rs2,
   output logic [4:0]        o_ex_rd,
   output logic              o_ex_reg_write,
   output logic              o_ex_mem_read,
   output logic              o_ex_mem_write,
   output logic              o_ex_mem_to_reg,
   output logic              o_ex_alu_src,
   output logic              o_ex_branch,
   output logic              o_ex_jump,
   output logic [3:0]        o_ex_alu_op,
   output logic              o_stall_if_id,
   output logic [CNT_W-1:0]  o_bubble_cnt
);

   logic              r_ex_valid;
   logic [XLEN-1:0]   r_ex_pc;
   logic [XLEN-1:0]   r_ex_rs1_data;
   logic [XLEN-1:0]   r_ex_rs2_data;
   logic [XLEN-1:0]   r_ex_imm;
   logic [4:0]        r_ex_rs1;
   logic [4:0]        r_ex_rs2;
   logic [4:0]        r_ex_rd;
   logic              r_ex_reg_write;
   logic              r_ex_mem_read;
   logic              r_ex_mem_write;
   logic              r_ex_mem_to_reg;
   logic              r_ex_alu_src;
   logic              r_ex_branch;
   logic              r_ex_jump;
   logic [3:0]        r_ex_alu_op;
   logic [CNT_W-1:0]  r_bubble_cnt;

   logic              w_load_use;
   logic              w_ctrl_en;
   logic [XLEN-1:0]   w_rs1_data;
   logic [XLEN-1:0]   w_rs2_data;

   // Load in EX whose destination (non-x0) is read by the real instruction in ID.
   always_comb begin
      w_load_use = r_ex_valid & r_ex_mem_read & (r_ex_rd != 5'd0) & i_id_valid &
                   ((r_ex_rd == i_id_rs1) | (r_ex_rd == i_id_rs2));
   end

   // A flush kills the consumer, so there is nothing left to hold back.
   assign o_stall_if_id = (w_load_use | i_stall_ex) & ~i_flush_ex;

   // An empty ID slot must never carry live control into EX.
   assign w_ctrl_en = i_id_valid;

`ifdef ID_WB_BYPASS_EN
   // Operand data picks up the same-cycle WB write (x0 is never forwarded).
   always_comb begin
      w_rs1_data = i_id_rs1_data;
      w_rs2_data = i_id_rs2_data;
      if (i_wb_reg_write && (i_wb_rd != 5'd0) && (i_wb_rd == i_id_rs1))
         w_rs1_data = i_wb_data;
      if (i_wb_reg_write && (i_wb_rd != 5'd0) && (i_wb_rd == i_id_rs2))
         w_rs2_data = i_wb_data;
   end
`else
   // Write-first register file: read data is already current.
   always_comb begin
      w_rs1_data = i_id_rs1_data;
      w_rs2_data = i_id_rs2_data;
   end

   // WB port kept on the boundary for a uniform interface; not consumed here.
   logic w_unused_wb;
   assign w_unused_wb = ^{i_wb_reg_write, i_wb_rd, i_wb_data};
`endif

   // Pipeline register update: reset, flush bubble, hold, load-use bubble, capture.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_ex_valid      <= 1'b0;
         r_ex_pc         <= '0;
         r_ex_rs1_data   <= '0;
         r_ex_rs2_data   <= '0;
         r_ex_imm        <= '0;
         r_ex_rs1        <= '0;
         r_ex_rs2        <= '0;
         r_ex_rd         <= '0;
         r_ex_reg_write  <= 1'b0;
         r_ex_mem_read   <= 1'b0;
         r_ex_mem_write  <= 1'b0;
         r_ex_mem_to_reg <= 1'b0;
         r_ex_alu_src    <= 1'b0;
         r_ex_branch     <= 1'b0;
         r_ex_jump       <= 1'b0;
         r_ex_alu_op     <= '0;
         r_bubble_cnt    <= '0;
      end else if (i_flush_ex || (!i_stall_ex && w_load_use)) begin
         // Bubble: everything zeroed; only a load-use bubble is counted.
         r_ex_valid      <= 1'b0;
         r_ex_pc         <= '0;
         r_ex_rs1_data   <= '0;
         r_ex_rs2_data   <= '0;
         r_ex_imm        <= '0;
         r_ex_rs1        <= '0;
         r_ex_rs2        <= '0;
         r_ex_rd         <= '0;
         r_ex_reg_write  <= 1'b0;
         r_ex_mem_read   <= 1'b0;
         r_ex_mem_write  <= 1'b0;
         r_ex_mem_to_reg <= 1'b0;
         r_ex_alu_src    <= 1'b0;
         r_ex_branch     <= 1'b0;
         r_ex_jump       <= 1'b0;
         r_ex_alu_op     <= '0;
         if (!i_flush_ex)
            r_bubble_cnt <= r_bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (!i_stall_ex) begin
         r_ex_valid      <= i_id_valid;
         r_ex_pc         <= i_id_pc;
         r_ex_rs1_data   <= w_rs1_data;
         r_ex_rs2_data   <= w_rs2_data;
         r_ex_imm        <= i_id_imm;
         r_ex_rs1        <= i_id_rs1;
         r_ex_rs2        <= i_id_rs2;
         r_ex_rd         <= i_id_rd;
         r_ex_reg_write  <= i_id_reg_write  & w_ctrl_en;
         r_ex_mem_read   <= i_id_mem_read   & w_ctrl_en;
         r_ex_mem_write  <= i_id_mem_write  & w_ctrl_en;
         r_ex_mem_to_reg <= i_id_mem_to_reg & w_ctrl_en;
         r_ex_alu_src    <= i_id_alu_src    & w_ctrl_en;
         r_ex_branch     <= i_id_branch     & w_ctrl_en;
         r_ex_jump       <= i_id_jump       & w_ctrl_en;
         r_ex_alu_op     <= w_ctrl_en ? i_id_alu_op : 4'd0;
      end
      // stall_ex alone: all state held
   end

   assign o_ex_valid      = r_ex_valid;
   assign o_ex_pc         = r_ex_pc;
   assign o_ex_rs1_data   = r_ex_rs1_data;
   assign o_ex_rs2_data   = r_ex_rs2_data;
   assign o_ex_imm        = r_ex_imm;
   assign o_ex_rs1        = r_ex_rs1;
   assign o_ex_rs2        = r_ex_rs2;
   assign o_ex_rd         = r_ex_rd;
   assign o_ex_reg_write  = r_ex_reg_write;
   assign o_ex_mem_read   = r_ex_mem_read;
   assign o_ex_mem_write  = r_ex_mem_write;
   assign o_ex_mem_to_reg = r_ex_mem_to_reg;
   assign o_ex_alu_src    = r_ex_alu_src;
   assign o_ex_branch     = r_ex_branch;
   assign o_ex_jump       = r_ex_jump;
   assign o_ex_alu_op     = r_ex_alu_op;
   assign o_bubble_cnt    = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and randomized checks of id_ex_stage against a
//   transaction-level model of the EX slot and the bubble counter.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [6:0]  id_ctrl;   // {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, jump}
   logic [3:0]  id_alu_op;
   logic        wb_reg_write;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        flush_ex, stall_ex;

   logic        ex_valid;
   logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
   logic        ex_alu_src, ex_branch, ex_jump;
   logic [3:0]  ex_alu_op;
   logic        stall_if_id;
   logic [31:0] bubble_cnt;

   always #5 clk = ~clk;

   id_ex_stage #(.XLEN(32), .CNT_W(32)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_id_valid(id_valid), .i_id_pc(id_pc),
      .i_id_rs1_data(id_rs1_data), .i_id_rs2_data(id_rs2_data), .i_id_imm(id_imm),
      .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_rd(id_rd),
      .i_id_reg_write(id_ctrl[6]), .i_id_mem_read(id_ctrl[5]), .i_id_mem_write(id_ctrl[4]),
      .i_id_mem_to_reg(id_ctrl[3]), .i_id_alu_src(id_ctrl[2]), .i_id_branch(id_ctrl[1]),
      .i_id_jump(id_ctrl[0]), .i_id_alu_op(id_alu_op),
      .i_wb_reg_write(wb_reg_write), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
      .i_flush_ex(flush_ex), .i_stall_ex(stall_ex),
      .o_ex_valid(ex_valid), .o_ex_pc(ex_pc),
      .o_ex_rs1_data(ex_rs1_data), .o_ex_rs2_data(ex_rs2_data), .o_ex_imm(ex_imm),
      .o_ex_rs1(ex_rs1), .o_ex_rs2(ex_rs2), .o_ex_rd(ex_rd),
      .o_ex_reg_write(ex_reg_write), .o_ex_mem_read(ex_mem_read), .o_ex_mem_write(ex_mem_write),
      .o_ex_mem_to_reg(ex_mem_to_reg), .o_ex_alu_src(ex_alu_src), .o_ex_branch(ex_branch),
      .o_ex_jump(ex_jump), .o_ex_alu_op(ex_alu_op),
      .o_stall_if_id(stall_if_id), .o_bubble_cnt(bubble_cnt)
   );

   // model of what EX should hold
   typedef struct packed {
      logic        valid;
      logic [31:0] pc, rs1d, rs2d, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [6:0]  ctrl;
      logic [3:0]  aluop;
   } slot_t;

   slot_t       m;
   logic [31:0] m_cnt;
   int          n_chk = 0;
   int          n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // EX holds a load whose result ID needs this cycle
   function automatic bit hazard();
      return m.valid && m.ctrl[5] && m.rd != 0 && id_valid &&
             (m.rd == id_rs1 || m.rd == id_rs2);
   endfunction

   function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] rf);
`ifdef ID_WB_BYPASS_EN
      if (wb_reg_write && wb_rd != 0 && wb_rd == idx) return wb_data;
`endif
      return rf;
   endfunction

   // advance the model by one clock edge given the present inputs
   task automatic model_step();
      slot_t nx;
      nx = m;
      if (!rst_n) begin
         nx = '0; m_cnt = 0;
      end else if (flush_ex) begin
         nx = '0;
      end else if (stall_ex) begin
         nx = m;
      end else if (hazard()) begin
         nx = '0; m_cnt = m_cnt + 1;
      end else begin
         nx.valid = id_valid;
         nx.pc    = id_pc;
         nx.rs1d  = operand(id_rs1, id_rs1_data);
         nx.rs2d  = operand(id_rs2, id_rs2_data);
         nx.imm   = id_imm;
         nx.rs1   = id_rs1;
         nx.rs2   = id_rs2;
         nx.rd    = id_rd;
         nx.ctrl  = id_valid ? id_ctrl : 7'd0;
         nx.aluop = id_valid ? id_alu_op : 4'd0;
      end
      m = nx;
   endtask

   task automatic check_outputs();
      chk("ex_valid", ex_valid, m.valid);
      chk("ex_pc", ex_pc, m.pc);
      chk("ex_rs1_data", ex_rs1_data, m.rs1d);
      chk("ex_rs2_data", ex_rs2_data, m.rs2d);
      chk("ex_imm", ex_imm, m.imm);
      chk("ex_idx", {ex_rs1, ex_rs2, ex_rd}, {m.rs1, m.rs2, m.rd});
      chk("ex_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                      ex_alu_src, ex_branch, ex_jump}, m.ctrl);
      chk("ex_alu_op", ex_alu_op, m.aluop);
      chk("bubble_cnt", bubble_cnt, m_cnt);
   endtask

   // check the combinational stall, clock once, check registered state
   task automatic tick();
      #1;
      chk("stall_if_id", stall_if_id, (hazard() || stall_ex) && !flush_ex);
      model_step();
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic [6:0] ctrl);
      id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_ctrl = ctrl;
      id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
      id_alu_op = 4'($urandom);
   endtask

   task automatic rnd_inputs();
      rst_n        = ($urandom_range(99) >= 3);
      flush_ex     = ($urandom_range(99) < 10);
      stall_ex     = ($urandom_range(99) < 15);
      id_valid     = ($urandom_range(99) < 85);
      id_pc        = $urandom;
      id_rs1_data  = $urandom;
      id_rs2_data  = $urandom;
      id_imm       = $urandom;
      id_rs1       = 5'($urandom_range(7));
      id_rs2       = 5'($urandom_range(7));
      id_rd        = 5'($urandom_range(7));
      id_ctrl      = 7'($urandom);
      id_ctrl[5]   = ($urandom_range(99) < 45);
      id_alu_op    = 4'($urandom);
      wb_reg_write = $urandom_range(1);
      wb_rd        = 5'($urandom_range(7));
      wb_data      = $urandom;
   endtask

   localparam logic [6:0] C_ALU  = 7'b1000100;  // reg_write, alu_src
   localparam logic [6:0] C_LOAD = 7'b1101100;  // reg_write, mem_read, mem_to_reg, alu_src

   initial begin
      m = '0; m_cnt = 0;
      rst_n = 1'b0; flush_ex = 0; stall_ex = 0;
      wb_reg_write = 0; wb_rd = 0; wb_data = 0;
      set_id(1'b1, 32'h40, 5'd1, 5'd2, 5'd3, C_LOAD);
      @(posedge clk); #1;

      // reset held with a valid ID instruction
      repeat (3) tick();
      chk("rst_valid", ex_valid, 1'b0);
      chk("rst_cnt", bubble_cnt, 32'd0);

      // plain capture
      rst_n = 1'b1;
      set_id(1'b1, 32'h100, 5'd1, 5'd2, 5'd5, C_ALU);
      tick();
      chk("cap_pc", ex_pc, 32'h100);
      chk("cap_rd", ex_rd, 5'd5);
      chk("cap_rw", ex_reg_write, 1'b1);

      // load-use: lw x6 then add reading x6 as rs2
      set_id(1'b1, 32'h104, 5'd1, 5'd2, 5'd6, C_LOAD);
      tick();
      set_id(1'b1, 32'h108, 5'd3, 5'd6, 5'd8, C_ALU);
      #1 chk("lu_stall", stall_if_id, 1'b1);
      tick();
      chk("lu_bubble_v", ex_valid, 1'b0);
      chk("lu_bubble_rw", ex_reg_write, 1'b0);
      chk("lu_cnt", bubble_cnt, 32'd1);
      tick();
      chk("lu_cap_pc", ex_pc, 32'h108);
      chk("lu_cap_v", ex_valid, 1'b1);

      // load to x0 never stalls
      set_id(1'b1, 32'h10c, 5'd1, 5'd2, 5'd0, C_LOAD);
      tick();
      set_id(1'b1, 32'h110, 5'd0, 5'd0, 5'd9, C_ALU);
      #1 chk("x0_stall", stall_if_id, 1'b0);
      tick();

      // load-use colliding with flush: flush wins
      set_id(1'b1, 32'h114, 5'd1, 5'd2, 5'd6, C_LOAD);
      tick();
      set_id(1'b1, 32'h118, 5'd6, 5'd2, 5'd9, C_ALU);
      flush_ex = 1'b1;
      #1 chk("fl_stall", stall_if_id, 1'b0);
      tick();
      flush_ex = 1'b0;
      chk("fl_bubble", ex_valid, 1'b0);
      chk("fl_cnt", bubble_cnt, 32'd1);

      // downstream stall holds contents for two cycles
      set_id(1'b1, 32'h200, 5'd4, 5'd5, 5'd10, C_ALU);
      tick();
      stall_ex = 1'b1;
      for (int i = 0; i < 2; i++) begin
         set_id(1'b1, 32'h300 + i, 5'd1, 5'd1, 5'd1, C_LOAD);
         #1 chk("st_stall", stall_if_id, 1'b1);
         tick();
         chk("st_hold_pc", ex_pc, 32'h200);
         chk("st_cnt", bubble_cnt, 32'd1);
      end
      stall_ex = 1'b0;

      // WB write colliding with rs1 read
      set_id(1'b1, 32'h400, 5'd7, 5'd2, 5'd11, C_ALU);
      id_rs1_data = 32'h0;
      wb_reg_write = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEADBEEF;
      tick();
`ifdef ID_WB_BYPASS_EN
      chk("byp_rs1", ex_rs1_data, 32'hDEADBEEF);
`else
      chk("byp_rs1", ex_rs1_data, 32'h0);
`endif
      wb_reg_write = 1'b0;

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rnd_inputs();
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register of the five-stage RV32I core, with integrated load-use hazard detection. It captures decoded operands and control from ID each cycle and presents them to EX. Its registered `ex_rs1`/`ex_rs2`/`ex_rd`/`ex_reg_write` feed the forwarding unit and the EX operand muxes. It stalls IF/ID and inserts a bubble when a load in EX is consumed by the instruction in ID. Inserting that bubble is a hazard forwarding cannot cover.

## Interface
- XLEN, 32, datapath width
- CNT_W, 32, width of bubble counter
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  PC of ID instruction
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  decoded immediate
- id_rs1, id_rs2, id_rd  in  5  register indices
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_branch, id_jump  in  1  decoded control
- id_alu_op  in  4  ALU operation
- wb_reg_write  in  1  WB stage writes register file
- wb_rd  in  5  WB destination
- wb_data  in  XLEN  WB write data
- flush_ex  in  1  branch/jump resolved taken in EX; kill ID instruction
- stall_ex  in  1  downstream stall; hold ID/EX contents
- ex_valid  out  1  EX holds a real instruction
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered copies
- ex_rs1, ex_rs2, ex_rd  out  5  registered indices (to forwarding unit)
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch, ex_jump  out  1  registered control
- ex_alu_op  out  4  registered ALU op
- stall_if_id  out  1  hold PC and IF/ID register (combinational)
- bubble_cnt  out  CNT_W  load-use bubbles inserted since reset

## Operation
- Load-use hazard: `load_use` = `ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2)`.
- `stall_if_id` = `(load_use | stall_ex) & ~flush_ex`.
- The register update is decided by the first matching row, in this priority order:
  1. `!rst_n`: all outputs are 0.
  2. `flush_ex`: bubble. `ex_valid` and all control outputs are 0. Data and index fields don't-care but driven 0.
  3. `stall_ex`: hold all contents.
  4. `load_use`: bubble, as in row 2. `bubble_cnt` increments.
  5. Otherwise: capture all `id_*` fields. `ex_valid` = `id_valid`. When `id_valid`=0, control outputs are forced to 0.
- A bubble must never assert `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_branch` or `ex_jump`.
- `bubble_cnt` wraps modulo 2^CNT_W. It is not incremented on flush or on `stall_ex` cycles.

## Timing
- ID to EX latency is one cycle. All `ex_*` outputs and `bubble_cnt` are registered.
- `stall_if_id` is combinational from current `ex_*` state and `id_*` inputs within the same cycle.
- A load-use pair produces exactly one bubble. Next cycle the load is in MEM, `load_use` deasserts, and the consumer is captured. The forwarding unit then supplies the operand from WB.
- Reset held mid-stall clears the pipeline. `stall_if_id` is 0 on the first cycle after reset release unless `stall_ex` is high.
- Simultaneous `flush_ex` and `load_use`: flush wins, `stall_if_id`=0, and the counter is unchanged.
- Simultaneous `stall_ex` and `load_use`: hold, and the counter is unchanged.

## Configuration
- `ID_WB_BYPASS_EN` defined: on capture (row 5), if `wb_reg_write & wb_rd!=0 & wb_rd==id_rs1`, `ex_rs1_data` takes `wb_data` instead of `id_rs1_data`. The same rule applies independently to rs2. This covers register files that are not write-first.
- Undefined: `id_rs*_data` is captured unmodified. The `wb_*` ports remain but are ignored, and the register file must be write-first.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `id_valid`=1 → all outputs 0, including `bubble_cnt`=0.
- Plain capture: `id_pc`=0x100, `id_rd`=5, `id_reg_write`=1 → next cycle `ex_pc`=0x100, `ex_rd`=5, `ex_reg_write`=1, `stall_if_id`=0.
- Load-use: EX holds lw x6 (`ex_mem_read`=1, `ex_rd`=6); ID presents add with `id_rs2`=6.
  - Same cycle: `stall_if_id`=1.
  - Next cycle: bubble (`ex_valid`=0, `ex_reg_write`=0), `bubble_cnt`=1.
  - Following cycle: the add is captured.
- x0 and flush:
  - Load with `ex_rd`=0 and `id_rs1`=0 → no stall.
  - Load-use with `flush_ex`=1 → `stall_if_id`=0, bubble, `bubble_cnt` unchanged.
- `stall_ex`=1 for 2 cycles → `ex_*` held constant, `stall_if_id`=1, no counter change.
- With `ID_WB_BYPASS_EN`: `wb_rd`=7, `wb_data`=0xDEADBEEF, `id_rs1`=7, `id_rs1_data`=0 → `ex_rs1_data`=0xDEADBEEF. Without the macro → `ex_rs1_data`=0.
